fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the 5-stage pipelined core: it owns the program counter, drives the instruction-memory address, and fills the fetch/decode pipeline register. It generalises the fixed PC+1 fetch path by adding a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so the next PC can be predicted. It also takes a redirect input from execute that overrides any prediction and squashes the instruction in flight. It sits between imem and the decode stage and replaces the standalone PC register and fetch/decode latch.

## Interface
- XLEN, 32, datapath/PC width
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX = log2(BTB_ENTRIES)
- RESET_PC, 0, PC value loaded on reset
- clock  in  1  master clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and the fetch/decode register (interlock or multdiv stall)
- redirect_valid  in  1  execute resolved a mispredict; squash and refetch
- redirect_pc  in  XLEN  correct next PC when redirect_valid=1
- update_valid  in  1  execute resolved a control-flow instruction; train the BTB
- update_pc  in  XLEN  PC of the resolved instruction
- update_target  in  XLEN  resolved target
- update_taken  in  1  resolved direction
- address_imem  out  XLEN  current fetch PC
- q_imem  in  32  instruction word at address_imem, valid in the same cycle
- fd_ir  out  32  fetch/decode instruction register
- fd_pc  out  XLEN  PC+1 of the instruction in fd_ir
- fd_valid  out  1  fd_ir holds a real instruction (0 = bubble)
- fd_pred_taken  out  1  prediction made for fd_ir
- fd_pred_target  out  XLEN  predicted target for fd_ir; forwarded so execute can detect a mispredict

## Operation
- PC is word-addressed. The sequential next PC is pc+1, with modulo 2^XLEN wrap-around and no flag.
- BTB entry contents: valid, tag = pc[XLEN-1:IDX], target[XLEN], ctr[2]. Index = pc[IDX-1:0].
- Lookup is combinational on the current pc.
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
- Next-PC priority:
  1. redirect_valid → redirect_pc
  2. stall → pc (hold)
  3. pred_taken → BTB target
  4. otherwise → pc+1
- Fetch/decode register, by the same priority:
  - redirect_valid: load a bubble (fd_ir=0, fd_valid=0, fd_pred_taken=0, fd_pred_target=0, fd_pc=0).
  - stall: hold all fd_* outputs.
  - otherwise: fd_ir=q_imem, fd_pc=pc+1, fd_valid=1, fd_pred_taken=pred_taken, fd_pred_target=BTB target (0 on miss).
- BTB update applies on an edge with update_valid=1. Stall and redirect do not block it.
  - Hit at update_pc, taken: ctr saturating increment (max 2'b11); target ← update_target.
  - Hit at update_pc, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate the entry, overwriting any alias. valid=1, tag from update_pc, target=update_target, ctr=2'b10.
  - Miss, not taken: no change.
- The ctr encodings 00/01/10/11 mean strong-NT, weak-NT, weak-T, strong-T.

## Timing
- Reset, asynchronous, takes effect immediately:
  - pc=RESET_PC, so address_imem=RESET_PC.
  - fd_ir=0, fd_pc=0, fd_valid=0, fd_pred_taken=0, fd_pred_target=0.
  - All BTB valid bits=0 and all ctr=2'b01.
- First instruction word appears on fd_ir one edge after reset deasserts.
- Latency from address_imem to fd_ir is 1 cycle. A predicted-taken target is fetched on the very next cycle (zero-bubble taken branch on a BTB hit).
- Redirect penalty: the squashed slot leaves exactly one bubble on fd_*. redirect_pc is on address_imem the cycle after the redirect edge.
- Redirect and stall on the same edge: redirect wins. The PC is loaded and the fd register is bubbled.
- Update and lookup to the same index on the same cycle: the lookup sees the pre-update contents. The new state becomes visible from the next cycle.
- Reset asserted mid-stall or mid-redirect: reset overrides everything, including pending BTB writes.
- No combinational path from redirect_*/update_* to address_imem. address_imem is a register output only.

## Test plan
- Reset with RESET_PC=0, no stalls → address_imem sequence 0,1,2,3. fd_pc is 1,2,3 one cycle behind. fd_valid=1 from the first edge after reset; fd_pred_taken=0 throughout.
- stall=1 for 3 cycles at pc=5 → address_imem stays 5 and fd_ir/fd_pc hold. After release, fetch resumes at 6.
- update_valid, update_pc=4, update_target=20, update_taken=1; then fetch reaches pc=4 → fd_pred_taken=1, fd_pred_target=20 and the next address_imem is 20 with no bubble. ctr reads 2'b10.
- Two not-taken updates at pc=4 (ctr 10→01→00), then fetch pc=4 → no prediction, next PC is 5. A further not-taken update keeps ctr=00 (saturates). Three taken updates from 00 end at ctr=11; a fourth keeps 11.
- redirect_valid with redirect_pc=40 while stall=1 → next address_imem=40, fd_valid=0, fd_ir=0 for one cycle, then fd_ir=q_imem(40) with fd_pc=41.
- Alias case with BTB_ENTRIES=16: a taken update at pc=4 (target 20), then fetch pc=20 (index 4, tag mismatch) → no prediction. A taken update at pc=20 (target 50) replaces the entry; fetch pc=4 then misses and pc=20 predicts 50.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's memory, pipeline-register and
// execute-feedback signals.
//   slave  modport - the fetch unit: consumes stall/redirect/update/q_imem,
//                    drives address_imem and the fd_* pipeline register.
//   master modport - the surrounding core (execute, imem, decode).
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            update_valid;
    logic [XLEN-1:0] update_pc;
    logic [XLEN-1:0] update_target;
    logic            update_taken;
    logic [XLEN-1:0] address_imem;
    logic [31:0]     q_imem;
    logic [31:0]     fd_ir;
    logic [XLEN-1:0] fd_pc;
    logic            fd_valid;
    logic            fd_pred_taken;
    logic [XLEN-1:0] fd_pred_target;

    modport slave (
        input  stall, redirect_valid, redirect_pc,
        input  update_valid, update_pc, update_target, update_taken,
        input  q_imem,
        output address_imem,
        output fd_ir, fd_pc, fd_valid, fd_pred_taken, fd_pred_target
    );

    modport master (
        output stall, redirect_valid, redirect_pc,
        output update_valid, update_pc, update_target, update_taken,
        output q_imem,
        input  address_imem,
        input  fd_ir, fd_pc, fd_valid, fd_pred_taken, fd_pred_target
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the word-addressed PC, drives
// the imem address and fills the fetch/decode register. A direct-mapped BTB
// with 2-bit saturating counters predicts taken branches; a redirect from
// execute overrides everything and squashes the slot in flight.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - fetch_unit_if.slave (stall, redirect_*, update_*, q_imem in;
//           address_imem, fd_* out)
module fetch_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.slave   bus
);
    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX;

    logic [XLEN-1:0]        r_pc;
    logic [31:0]            r_fd_ir;
    logic [XLEN-1:0]        r_fd_pc;
    logic                   r_fd_valid;
    logic                   r_fd_pred_taken;
    logic [XLEN-1:0]        r_fd_pred_target;

    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_btb_target [BTB_ENTRIES];
    logic [1:0]             r_btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]         w_lk_idx;
    logic                   w_lk_hit;
    logic                   w_pred_taken;
    logic [XLEN-1:0]        w_pred_target;
    logic [XLEN-1:0]        w_pc_inc;
    logic [IDX-1:0]         w_up_idx;
    logic                   w_up_hit;

    // Lookup on the current PC reads pre-update BTB state; a same-cycle
    // update only becomes visible on the following cycle.
    always_comb begin
        w_lk_idx      = r_pc[IDX-1:0];
        w_lk_hit      = r_btb_valid[w_lk_idx] &&
                        (r_btb_tag[w_lk_idx] == r_pc[XLEN-1:IDX]);
        w_pred_taken  = w_lk_hit && r_btb_ctr[w_lk_idx][1];
        w_pred_target = w_lk_hit ? r_btb_target[w_lk_idx] : '0;
        w_pc_inc      = r_pc + XLEN'(1);
        w_up_idx      = bus.update_pc[IDX-1:0];
        w_up_hit      = r_btb_valid[w_up_idx] &&
                        (r_btb_tag[w_up_idx] == bus.update_pc[XLEN-1:IDX]);
    end

    // PC and fetch/decode register: redirect > stall > prediction > pc+1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_fd_ir          <= '0;
            r_fd_pc          <= '0;
            r_fd_valid       <= 1'b0;
            r_fd_pred_taken  <= 1'b0;
            r_fd_pred_target <= '0;
        end else if (bus.redirect_valid) begin
            r_pc             <= bus.redirect_pc;
            r_fd_ir          <= '0;
            r_fd_pc          <= '0;
            r_fd_valid       <= 1'b0;
            r_fd_pred_taken  <= 1'b0;
            r_fd_pred_target <= '0;
        end else if (!bus.stall) begin
            r_pc             <= w_pred_taken ? w_pred_target : w_pc_inc;
            r_fd_ir          <= bus.q_imem;
            r_fd_pc          <= w_pc_inc;
            r_fd_valid       <= 1'b1;
            r_fd_pred_taken  <= w_pred_taken;
            r_fd_pred_target <= w_pred_target;
        end
    end

    // BTB training runs independently of stall and redirect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_btb_valid <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
                r_btb_ctr[i]    <= 2'b01;
            end
        end else if (bus.update_valid) begin
            if (w_up_hit) begin
                if (bus.update_taken) begin
                    r_btb_ctr[w_up_idx]    <= (r_btb_ctr[w_up_idx] == 2'b11) ?
                                              2'b11 : r_btb_ctr[w_up_idx] + 2'b01;
                    r_btb_target[w_up_idx] <= bus.update_target;
                end else begin
                    r_btb_ctr[w_up_idx]    <= (r_btb_ctr[w_up_idx] == 2'b00) ?
                                              2'b00 : r_btb_ctr[w_up_idx] - 2'b01;
                end
            end else if (bus.update_taken) begin
                // Allocation overwrites whatever alias occupies the slot.
                r_btb_valid[w_up_idx]  <= 1'b1;
                r_btb_tag[w_up_idx]    <= bus.update_pc[XLEN-1:IDX];
                r_btb_target[w_up_idx] <= bus.update_target;
                r_btb_ctr[w_up_idx]    <= 2'b10;
            end
        end
    end

    assign bus.address_imem   = r_pc;
    assign bus.fd_ir          = r_fd_ir;
    assign bus.fd_pc          = r_fd_pc;
    assign bus.fd_valid       = r_fd_valid;
    assign bus.fd_pred_taken  = r_fd_pred_taken;
    assign bus.fd_pred_target = r_fd_pred_target;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit. The stimulus process queues the
// hand-computed fetch-stage state expected after each edge; a monitor process
// pops one expectation per cycle on the falling edge and compares.
module tb_fetch_unit;
    localparam int unsigned XLEN = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (16),
        .RESET_PC    (32'd0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory model: combinational, nonzero at every address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE0000 ^ (a * 32'd7);
    endfunction

    assign bus.q_imem = mem(bus.address_imem);

    typedef struct packed {
        logic [31:0] a;
        logic        v;
        logic [31:0] ir;
        logic [31:0] fp;
        logic        pt;
        logic [31:0] ptg;
    } exp_t;

    exp_t  q  [$];
    string qn [$];
    int    errors = 0;
    int    checks = 0;
    logic  done   = 1'b0;

    // Monitor: one expectation per falling edge.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string n;
            e = q.pop_front();
            n = qn.pop_front();
            g = '{a: bus.address_imem, v: bus.fd_valid, ir: bus.fd_ir,
                  fp: bus.fd_pc, pt: bus.fd_pred_taken, ptg: bus.fd_pred_target};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got addr=%h v=%b ir=%h pc=%h pt=%b ptg=%h ; want addr=%h v=%b ir=%h pc=%h pt=%b ptg=%h",
                         n, g.a, g.v, g.ir, g.fp, g.pt, g.ptg,
                         e.a, e.v, e.ir, e.fp, e.pt, e.ptg);
            end
        end
    end

    // Watchdog: the directed sequence must complete in bounded time.
    initial begin
        #20000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: stimulus did not complete");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic push(input string n, input logic [31:0] a, input logic v,
                        input logic [31:0] fp, input logic pt, input logic [31:0] ptg);
        exp_t e;
        e.a   = a;
        e.v   = v;
        e.ir  = v ? mem(fp - 32'd1) : 32'd0;
        e.fp  = fp;
        e.pt  = pt;
        e.ptg = ptg;
        q.push_back(e);
        qn.push_back(n);
    endtask

    // Expected state after the next rising edge, then advance one cycle.
    task automatic step(input string n, input logic [31:0] a, input logic v,
                        input logic [31:0] fp, input logic pt, input logic [31:0] ptg);
        push(n, a, v, fp, pt, ptg);
        @(posedge clock);
        #1;
    endtask

    task automatic redir(input string n, input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step(n, target, 1'b0, 32'd0, 1'b0, 32'd0);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic tk);
        bus.update_valid  = v;
        bus.update_pc     = pc;
        bus.update_target = tgt;
        bus.update_taken  = tk;
    endtask

    initial begin
        reset              = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        upd(1'b0, 32'd0, 32'd0, 1'b0);

        // Asynchronous reset state, checked while reset is held.
        #1;
        checks++;
        if (bus.address_imem !== 32'd0 || bus.fd_ir !== 32'd0 || bus.fd_pc !== 32'd0 ||
            bus.fd_valid !== 1'b0 || bus.fd_pred_taken !== 1'b0 ||
            bus.fd_pred_target !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: addr=%h ir=%h pc=%h v=%b pt=%b ptg=%h",
                     bus.address_imem, bus.fd_ir, bus.fd_pc, bus.fd_valid,
                     bus.fd_pred_taken, bus.fd_pred_target);
        end

        step("reset", 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        reset = 1'b0;

        // Sequential fetch from RESET_PC.
        step("seq1", 32'd1, 1'b1, 32'd1, 1'b0, 32'd0);
        step("seq2", 32'd2, 1'b1, 32'd2, 1'b0, 32'd0);
        step("seq3", 32'd3, 1'b1, 32'd3, 1'b0, 32'd0);
        step("seq4", 32'd4, 1'b1, 32'd4, 1'b0, 32'd0);
        step("seq5", 32'd5, 1'b1, 32'd5, 1'b0, 32'd0);

        // Stall holds PC and fd.
        bus.stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) step("stall_hold", 32'd5, 1'b1, 32'd5, 1'b0, 32'd0);
        bus.stall = 1'b0;
        step("stall_resume", 32'd6, 1'b1, 32'd6, 1'b0, 32'd0);

        // Allocate pc=4 -> 20 (ctr 10), then fetch it: zero-bubble taken.
        upd(1'b1, 32'd4, 32'd20, 1'b1);
        step("alloc", 32'd7, 1'b1, 32'd7, 1'b0, 32'd0);
        upd(1'b0, 32'd0, 32'd0, 1'b0);
        redir("redir4_a", 32'd4);
        step("pred_taken", 32'd20, 1'b1, 32'd5, 1'b1, 32'd20);
        step("alias_miss", 32'd21, 1'b1, 32'd21, 1'b0, 32'd0);

        // Two not-taken updates: 10 -> 01 -> 00; hit but predicted not taken.
        upd(1'b1, 32'd4, 32'd0, 1'b0);
        step("nt1", 32'd22, 1'b1, 32'd22, 1'b0, 32'd0);
        step("nt2", 32'd23, 1'b1, 32'd23, 1'b0, 32'd0);
        upd(1'b0, 32'd0, 32'd0, 1'b0);
        redir("redir4_b", 32'd4);
        step("ctr00_nt", 32'd5, 1'b1, 32'd5, 1'b0, 32'd20);

        // NT at 00 stays 00; one taken then gives 01 (still not taken).
        upd(1'b1, 32'd4, 32'd0, 1'b0);
        step("nt_sat", 32'd6, 1'b1, 32'd6, 1'b0, 32'd0);
        upd(1'b1, 32'd4, 32'd24, 1'b1);
        step("t_from00", 32'd7, 1'b1, 32'd7, 1'b0, 32'd0);
        upd(1'b0, 32'd0, 32'd0, 1'b0);
        redir("redir4_c", 32'd4);
        step("ctr01_nt", 32'd5, 1'b1, 32'd5, 1'b0, 32'd24);

        // 01 -> 10 -> 11 -> 11 (saturate), then NT -> 10: taken again.
        upd(1'b1, 32'd4, 32'd24, 1'b1);
        step("t_a", 32'd6, 1'b1, 32'd6, 1'b0, 32'd0);
        step("t_b", 32'd7, 1'b1, 32'd7, 1'b0, 32'd0);
        step("t_sat", 32'd8, 1'b1, 32'd8, 1'b0, 32'd0);
        upd(1'b1, 32'd4, 32'd0, 1'b0);
        step("nt_from11", 32'd9, 1'b1, 32'd9, 1'b0, 32'd0);
        upd(1'b0, 32'd0, 32'd0, 1'b0);
        redir("redir4_d", 32'd4);
        step("ctr10_t", 32'd24, 1'b1, 32'd5, 1'b1, 32'd24);
        step("seq24", 32'd25, 1'b1, 32'd25, 1'b0, 32'd0);

        // Redirect wins over stall; one bubble, then refetch at 40.
        bus.stall = 1'b1;
        redir("redir_stall", 32'd40);
        bus.stall = 1'b0;
        step("after_redir", 32'd41, 1'b1, 32'd41, 1'b0, 32'd0);
        step("seq41", 32'd42, 1'b1, 32'd42, 1'b0, 32'd0);

        // Same-cycle update and lookup at pc=42: lookup sees old (miss).
        upd(1'b1, 32'd42, 32'd60, 1'b1);
        step("same_cycle", 32'd43, 1'b1, 32'd43, 1'b0, 32'd0);
        upd(1'b0, 32'd0, 32'd0, 1'b0);
        redir("redir42", 32'd42);
        step("upd_visible", 32'd60, 1'b1, 32'd43, 1'b1, 32'd60);

        // Alias replacement: pc=20 takes over index 4.
        upd(1'b1, 32'd20, 32'd50, 1'b1);
        step("alias_upd", 32'd61, 1'b1, 32'd61, 1'b0, 32'd0);
        upd(1'b0, 32'd0, 32'd0, 1'b0);
        redir("redir4_e", 32'd4);
        step("alias_gone", 32'd5, 1'b1, 32'd5, 1'b0, 32'd0);
        redir("redir20", 32'd20);
        step("alias_new", 32'd50, 1'b1, 32'd21, 1'b1, 32'd50);
        step("seq50", 32'd51, 1'b1, 32'd51, 1'b0, 32'd0);

        // PC wrap-around.
        redir("redir_max", 32'hFFFF_FFFF);
        step("wrap", 32'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        step("wrap2", 32'd1, 1'b1, 32'd1, 1'b0, 32'd0);

        // Reset during stall with a pending BTB write: reset wins.
        push("reset_mid", 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clock);
        #1;
        reset     = 1'b1;
        bus.stall = 1'b1;
        upd(1'b1, 32'd0, 32'd99, 1'b1);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        bus.stall = 1'b0;
        upd(1'b0, 32'd0, 32'd0, 1'b0);
        step("post_reset", 32'd1, 1'b1, 32'd1, 1'b0, 32'd0);
        redir("redir20_b", 32'd20);
        step("btb_cleared", 32'd21, 1'b1, 32'd21, 1'b0, 32'd0);

        repeat (3) @(posedge clock);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
